cdce_spi_serializer: RTL and testbench
======================================

// Module: cdce_spi_serializer
// PURPOSE
//  Serial back end for the CDCE command path. Consumes the 32-bit cdce_command word and the
//  start_transaction pulse from the command controller. Shifts the word LSB-first to the
//  CDCE device over SPI_LE/SPI_CLK/SPI_MOSI, and reports serial_ready for the next ROM fetch.
// PARAMETERS
//  HALF_PERIOD  2   clk cycles per SPI_CLK half period (legal range 1..255)
//  GAP_CYCLES   4   clk cycles spi_le held high after a word before serial_ready returns (0..255)
// PORTS
//  clk                input   1   system clock
//  reset_n            input   1   asynchronous reset, active-low
//  start_transaction  input   1   one-cycle request; accepted only when serial_ready=1
//  cdce_command       input   32  word to send; sampled in the accept cycle only
//  serial_ready       output  1   1 = idle, a new request can be accepted
//  spi_le             output  1   CDCE latch enable; low during the shift, rising edge latches
//  spi_clk            output  1   SPI clock, idle low; CDCE samples mosi on the rising edge
//  spi_mosi           output  1   serial data, LSB (bit 0) first
//  spi_miso           input   1   CDCE readback data (used only with CDCE_READBACK_EN)
//  read_data          output  32  captured readback word (only with CDCE_READBACK_EN)
//  read_valid         output  1   1-cycle pulse when read_data updates (only with CDCE_READBACK_EN)
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: spi_le=1, spi_clk=0, spi_mosi=0, serial_ready=0, read_data=0, read_valid=0,
//    state=IDLE, all counters 0.
//  - After reset deasserts, serial_ready goes to 1 on the first clk edge.
//  - Reset mid-word aborts at once: spi_le returns high with no clean latch. The word is lost.
//  - States: IDLE -> SHIFT_LO -> SHIFT_HI -> (repeat per bit) -> HOLD -> GAP -> IDLE.
//  - IDLE: serial_ready=1, spi_le=1, spi_clk=0.
//    On start_transaction=1, the edge that accepts the request does all of the following:
//      shift reg <= cdce_command, spi_le <= 0, spi_mosi <= cdce_command[0],
//      serial_ready <= 0, bit_cnt <= 0, div_cnt <= 0; next state SHIFT_LO.
//  - SHIFT_LO: spi_clk=0 for HALF_PERIOD cycles, mosi stable; then spi_clk <= 1, go to SHIFT_HI.
//  - SHIFT_HI: spi_clk=1 for HALF_PERIOD cycles. Then spi_clk <= 0.
//    If bit_cnt==31, go to HOLD. Else bit_cnt+1, mosi <= next bit, go to SHIFT_LO.
//  - HOLD: spi_clk=0, spi_le=0 for HALF_PERIOD cycles (le hold after the last edge).
//    Then spi_le <= 1 and mosi <= 0. Go to GAP, or to IDLE when GAP_CYCLES=0.
//  - GAP: spi_le=1 for GAP_CYCLES cycles, then IDLE.
//  - Totals: spi_le low for exactly 65*HALF_PERIOD cycles; 32 spi_clk rising edges per word.
//    serial_ready is low for 65*HALF_PERIOD + GAP_CYCLES + 1 cycles per word.
//  - div_cnt is 8 bits and compared to HALF_PERIOD-1. bit_cnt is 5 bits and stops at 31;
//    it never wraps mid-word.
//  - start_transaction while serial_ready=0 is ignored: not queued, no effect on the current word.
//  - cdce_command changes after the accept cycle have no effect (the upstream ROM address may advance).
//  - start held high for several cycles is accepted once. It is re-accepted only if still high
//    when the block next returns to IDLE.
// CONFIGURATION
//  CDCE_READBACK_EN defined:
//    - spi_miso is sampled on each spi_clk falling transition (end of SHIFT_HI) into a
//      32-bit LSB-first capture reg.
//    - On entry to HOLD: read_data <= capture, read_valid pulses for 1 cycle.
//  CDCE_READBACK_EN undefined:
//    - no capture logic; spi_miso is unused.
//    - read_data is tied to 32'h0 and read_valid to 0.
// TESTING
//  1. Reset release, HALF_PERIOD=2, GAP_CYCLES=4 -> serial_ready=1 one cycle later;
//     spi_le=1, spi_clk=0.
//  2. Start with cmd=32'h8000_0001 -> spi_le low 130 cycles, 32 rising spi_clk edges,
//     mosi=1 at edge 0 and edge 31, 0 otherwise; serial_ready low 135 cycles.
//  3. Start with cmd=32'hA5A5_0F0F, then change cdce_command next cycle -> bits 0..31 sampled
//     at the rising edges equal 32'hA5A5_0F0F.
//  4. Second start pulse 10 cycles into a word -> ignored: still exactly 32 edges, one le rise,
//     then serial_ready=1.
//  5. Assert reset_n=0 at spi_clk edge 16 -> spi_le=1, spi_clk=0, serial_ready=0 immediately.
//     Next start after release sends a full word.
//  6. CDCE_READBACK_EN, spi_miso driven with 32'h1234_5678 LSB-first -> read_data=32'h1234_5678,
//     read_valid pulses 1 cycle at HOLD entry.

Source files
------------

// File: rtl/cdce_spi_serializer.sv
// CDCE SPI serializer: shifts a 32-bit command word LSB-first over SPI_LE/SPI_CLK/SPI_MOSI.
// Define CDCE_READBACK_EN to capture spi_miso into read_data/read_valid.
module cdce_spi_serializer #(
  parameter int HALF_PERIOD = 2,
  parameter int GAP_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_transaction,
  input  logic [31:0] cdce_command,
  output logic        serial_ready,
  output logic        spi_le,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [31:0] read_data,
  output logic        read_valid
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam bit         HAS_GAP  = (GAP_CYCLES != 0);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  // Bits still to be sent; bit 0 is always the next mosi value.
  logic [30:0] shift_q, shift_d;
  logic        le_q, le_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic        div_done;

`ifdef CDCE_READBACK_EN
  logic [30:0] cap_q, cap_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
`endif

  assign div_done = (div_q == HP_LAST);

  // NOTE: every signal gets its hold value first, so no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    le_d    = le_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ready_d = ready_q;
`ifdef CDCE_READBACK_EN
    cap_d    = cap_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        le_d   = 1'b1;
        sclk_d = 1'b0;
        if (ready_q && start_transaction) begin
          shift_d = {1'b0, cdce_command[31:1]};
          mosi_d  = cdce_command[0];
          le_d    = 1'b0;
          ready_d = 1'b0;
          bit_d   = 5'd0;
          div_d   = 8'd0;
          state_d = SHIFT_LO;
        end else begin
          // Ready rises one edge after re-entering IDLE, so a held start waits that cycle.
          ready_d = 1'b1;
        end
      end

      SHIFT_LO: begin
        if (div_done) begin
          div_d   = 8'd0;
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      SHIFT_HI: begin
        if (div_done) begin
          div_d  = 8'd0;
          sclk_d = 1'b0;
`ifdef CDCE_READBACK_EN
          cap_d = {spi_miso, cap_q[30:1]};
`endif
          if (bit_q == 5'd31) begin
            state_d = HOLD;
`ifdef CDCE_READBACK_EN
            rdata_d  = {spi_miso, cap_q};
            rvalid_d = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 5'd1;
            mosi_d  = shift_q[0];
            shift_d = {1'b0, shift_q[30:1]};
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      HOLD: begin
        if (div_done) begin
          div_d   = 8'd0;
          le_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = HAS_GAP ? GAP : IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      GAP: begin
        if (div_q == GAP_LAST) begin
          div_d   = 8'd0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        div_d   = 8'd0;
        le_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      bit_q   <= 5'd0;
      shift_q <= 31'd0;
      le_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      le_q    <= le_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
    end
  end

  assign serial_ready = ready_q;
  assign spi_le       = le_q;
  assign spi_clk      = sclk_q;
  assign spi_mosi     = mosi_q;

`ifdef CDCE_READBACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q    <= 31'd0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
    end else begin
      cap_q    <= cap_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign read_data  = rdata_q;
  assign read_valid = rvalid_q;
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign read_data   = 32'h0;
  assign read_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_cdce_spi_serializer.sv
// Directed bench for cdce_spi_serializer (HALF_PERIOD=2, GAP_CYCLES=4).
// A negedge monitor records spi_clk edges, mosi bits, le/ready low time and readback pulses.
module tb_cdce_spi_serializer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_transaction = 1'b0;
  logic [31:0] cdce_command = 32'h0;
  logic        serial_ready;
  logic        spi_le;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic [31:0] read_data;
  logic        read_valid;

  cdce_spi_serializer #(.HALF_PERIOD(2), .GAP_CYCLES(4)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start_transaction (start_transaction),
    .cdce_command      (cdce_command),
    .serial_ready      (serial_ready),
    .spi_le            (spi_le),
    .spi_clk           (spi_clk),
    .spi_mosi          (spi_mosi),
    .spi_miso          (spi_miso),
    .read_data         (read_data),
    .read_valid        (read_valid)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic        mon_clear = 1'b0;
  logic [31:0] miso_pat  = 32'h0;
  int          edges     = 0;
  int          le_low    = 0;
  int          le_rises  = 0;
  int          ready_low = 0;
  int          rv_cnt    = 0;
  logic        rv_le     = 1'b1;
  logic [31:0] mosi_word = 32'h0;
  logic        prev_sclk = 1'b0;
  logic        prev_le   = 1'b1;

  always @(negedge clk) begin
    if (mon_clear) begin
      edges     = 0;
      le_low    = 0;
      le_rises  = 0;
      ready_low = 0;
      rv_cnt    = 0;
      rv_le     = 1'b1;
      mosi_word = 32'h0;
    end else begin
      if (spi_clk && !prev_sclk) begin
        if (edges < 32) begin
          mosi_word[edges] = spi_mosi;
          spi_miso = miso_pat[edges];
        end
        edges = edges + 1;
      end
      if (!spi_le) le_low = le_low + 1;
      if (spi_le && !prev_le) le_rises = le_rises + 1;
      if (!serial_ready) ready_low = ready_low + 1;
      if (read_valid) begin
        rv_cnt = rv_cnt + 1;
        rv_le  = spi_le;
      end
    end
    prev_sclk = spi_clk;
    prev_le   = spi_le;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clear = 1'b1;
    step();
    mon_clear = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!serial_ready && n < 400) begin
      step();
      n++;
    end
    if (!serial_ready) check({tag, "_timeout"}, 32'(serial_ready), 32'd1);
  endtask

  task automatic send(input logic [31:0] cmd);
    cdce_command = cmd;
    start_transaction = 1'b1;
    step();
    start_transaction = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    check("rst_ready", 32'(serial_ready), 32'd0);
    check("rst_le",    32'(spi_le),       32'd1);
    check("rst_sclk",  32'(spi_clk),      32'd0);
    check("rst_mosi",  32'(spi_mosi),     32'd0);
    check("rst_rdata", read_data,         32'h0);
    reset_n = 1'b1;
    step();
    check("rel_ready", 32'(serial_ready), 32'd1);
    check("rel_le",    32'(spi_le),       32'd1);
    check("rel_sclk",  32'(spi_clk),      32'd0);

    // Single-bit ends: mosi high only at edges 0 and 31.
    clear_mon();
    send(32'h8000_0001);
    wait_ready("w1");
    step();
    check("w1_le_low",    32'(le_low),    32'd130);
    check("w1_edges",     32'(edges),     32'd32);
    check("w1_word",      mosi_word,      32'h8000_0001);
    check("w1_ready_low", 32'(ready_low), 32'd135);
    check("w1_le_rises",  32'(le_rises),  32'd1);
`ifndef CDCE_READBACK_EN
    check("w1_rdata_tied", read_data,      32'h0);
    check("w1_rvalid_cnt", 32'(rv_cnt),    32'd0);
`endif

    // Command changes right after the accept cycle must not leak into the word.
    clear_mon();
    send(32'hA5A5_0F0F);
    cdce_command = 32'hFFFF_FFFF;
    step();
    cdce_command = 32'h0000_0000;
    wait_ready("w2");
    step();
    check("w2_word",  mosi_word,   32'hA5A5_0F0F);
    check("w2_edges", 32'(edges),  32'd32);

    // Second start 10 cycles into the word is ignored.
    clear_mon();
    send(32'h0000_FFFF);
    repeat (9) step();
    cdce_command = 32'h1234_5678;
    start_transaction = 1'b1;
    step();
    start_transaction = 1'b0;
    wait_ready("w3");
    repeat (3) step();
    check("w3_edges",     32'(edges),     32'd32);
    check("w3_le_rises",  32'(le_rises),  32'd1);
    check("w3_word",      mosi_word,      32'h0000_FFFF);
    check("w3_ready_low", 32'(ready_low), 32'd135);
    check("w3_ready",     32'(serial_ready), 32'd1);

    // Start held high across a whole word is accepted exactly twice over 200 cycles.
    clear_mon();
    cdce_command = 32'h0F0F_0F0F;
    start_transaction = 1'b1;
    repeat (200) step();
    start_transaction = 1'b0;
    wait_ready("w4");
    repeat (3) step();
    check("w4_le_rises", 32'(le_rises), 32'd2);
    check("w4_edges",    32'(edges),    32'd64);

    // Reset at rising edge 16 aborts the word at once.
    clear_mon();
    send(32'hFFFF_FFFF);
    begin
      int n = 0;
      while (edges < 16 && n < 200) begin
        step();
        n++;
      end
    end
    check("w5_reached_edge16", 32'(edges), 32'd16);
    reset_n = 1'b0;
    #1;
    check("w5_abort_le",    32'(spi_le),       32'd1);
    check("w5_abort_sclk",  32'(spi_clk),      32'd0);
    check("w5_abort_ready", 32'(serial_ready), 32'd0);
    step();
    reset_n = 1'b1;
    wait_ready("w5");
    clear_mon();
    send(32'h5A5A_C3C3);
    wait_ready("w6");
    step();
    check("w6_word",     mosi_word,     32'h5A5A_C3C3);
    check("w6_edges",    32'(edges),    32'd32);
    check("w6_le_low",   32'(le_low),   32'd130);

`ifdef CDCE_READBACK_EN
    miso_pat = 32'h1234_5678;
    clear_mon();
    send(32'h0000_0000);
    wait_ready("w7");
    step();
    check("w7_rdata",     read_data,    32'h1234_5678);
    check("w7_rvalid_cnt", 32'(rv_cnt), 32'd1);
    check("w7_rvalid_le", 32'(rv_le),   32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
